falling_block: RTL and testbench
================================

# falling_block

Parametrised successor to the fixed-position block/background sprites: a grid-quantised falling game piece that advances one row every GRAV_PERIOD frames and responds to edge-detected keyboard commands. It sits between the USB keycode path and the color mapper, outputs a pixel-space centre and half-size in the same convention as the existing sprite modules, and consults the playfield through per-direction "cell free" inputs. It runs once per frame on frame_clk.

## Interface
- COLS, 10, playfield width in cells
- ROWS, 20, playfield height in cells
- CELL, 24, cell edge in pixels
- X_ORIGIN, 200, playfield left edge, pixels
- Y_ORIGIN, 0, playfield top edge, pixels
- GRAV_PERIOD, 30, frames per gravity step (≥2)
- SPAWN_COL, 4, spawn column (<COLS)
- frame_clk  in  1  frame-rate clock; all state on posedge
- Reset  in  1  synchronous, active-high reset
- keycode  in  8  current USB HID keycode (0x00 = none)
- free_left  in  1  cell at (col-1,row) is empty
- free_right  in  1  cell at (col+1,row) is empty
- free_down  in  1  cell at (col,row+1) is empty
- BlockX  out  10  centre X, pixels
- BlockY  out  10  centre Y, pixels
- BlockS  out  10  half-size, pixels (constant CELL/2)
- col  out  $clog2(COLS)  current column
- row  out  $clog2(ROWS)  current row
- landed  out  1  one-cycle pulse when piece locks

## Operation
- States: SPAWN -> FALL -> LANDED -> SPAWN.
- SPAWN: col=SPAWN_COL, row=0, gcnt=0; go to FALL next cycle. No key action.
- FALL: key press = keycode≠0 and keycode≠prev keycode (registered). Held keys do not repeat.
  - 0x04 (A): col-1 if col>0 and free_left.
  - 0x07 (D): col+1 if col<COLS-1 and free_right.
  - 0x16 (S): soft drop; treated as immediate gravity step, gcnt cleared.
  - Other codes ignored.
- Gravity: gcnt increments each FALL cycle; at gcnt==GRAV_PERIOD-1 a step occurs, gcnt->0.
- Step: if row<ROWS-1 and free_down, row+1; else go to LANDED.
- Simultaneous horizontal press and gravity step: horizontal applied, gravity deferred (gcnt holds at GRAV_PERIOD-1, step next cycle). free_* always refer to the current position.
- LANDED: landed=1 for exactly this cycle; col/row hold; next state SPAWN.
- BlockX = X_ORIGIN + col*CELL + CELL/2; BlockY = Y_ORIGIN + row*CELL + CELL/2; 10-bit unsigned; parameters must keep results <1024.

## Timing
- Reset (sampled on frame_clk): state=SPAWN, col=SPAWN_COL, row=0, gcnt=0, prev keycode=0, landed=0; BlockX/BlockY = spawn centre, BlockS=CELL/2.
- Reset mid-fall or in LANDED: discards the piece and suppresses landed; next cycle is SPAWN.
- Key to position: 1 cycle (registered on the edge where the press is detected).
- Outputs registered col/row; BlockX/BlockY combinational from them.
- Landing latency: step with blocked down -> landed high the following cycle.
- Spawn to first gravity step: 1 + GRAV_PERIOD cycles.

## Configuration
- HARD_DROP_EN: when defined, 0x2C (space) press in FALL sets row to the lowest reachable row by stepping one row per cycle while free_down (key input ignored during the drop), then enters LANDED. When not defined, 0x2C is ignored like any other code.

## Structure
- Package falling_block_pkg: keycode constants (KEY_A, KEY_D, KEY_S, KEY_SPACE), state enum fb_state_t {SPAWN, FALL, LANDED, DROP}, DROP present only under HARD_DROP_EN.
- Sub-module key_edge: registers the previous keycode and emits an 8-bit press code plus a press valid.

## Test plan
- Reset, default params -> col=4, row=0, BlockX=308, BlockY=12, BlockS=12, landed=0.
- All free, no keys, 31 frames after reset -> row=1, BlockY=36; after a further 30 -> row=2.
- keycode 0x04 held for 10 frames -> col drops by exactly 1; at col=0, further A presses leave col=0.
- free_down=0 at gravity step -> landed pulses one cycle the next frame, then SPAWN restores col=4, row=0.
- A press on the gravity frame -> col changes that frame; row increments the following frame.
- HARD_DROP_EN, space press at row=0 with free_down until row 19 -> row reaches 19 in 19 cycles, landed pulses once; without macro, row unchanged.

Source files
------------

// File: rtl/falling_block_pkg.sv
// rtl/falling_block_pkg.sv - shared keycodes and state encoding for falling_block
// Purpose: USB HID keycode constants and the falling-piece state enum.
// Configuration: HARD_DROP_EN adds the DROP state.
package falling_block_pkg;

  localparam logic [7:0] KEY_A     = 8'h04;
  localparam logic [7:0] KEY_D     = 8'h07;
  localparam logic [7:0] KEY_S     = 8'h16;
  localparam logic [7:0] KEY_SPACE = 8'h2C;

  typedef enum logic [1:0] {
    SPAWN,
    FALL,
    LANDED
`ifdef HARD_DROP_EN
    , DROP
`endif
  } fb_state_t;

endpackage

// File: rtl/falling_block_key_edge.sv
// rtl/falling_block_key_edge.sv - keycode press detector
// Purpose: remembers last frame's keycode so a held key yields one press only.
// Ports:
//   frame_clk   in   frame-rate clock
//   Reset       in   synchronous active-high reset
//   keycode     in   current USB HID keycode
//   press_code  out  keycode of a new press, 0 otherwise
//   press_valid out  a new non-zero keycode appeared this frame
module key_edge (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [7:0] keycode,
  output logic [7:0] press_code,
  output logic       press_valid
);

  logic [7:0] prev;

  always_ff @(posedge frame_clk) begin
    if (Reset) prev <= 8'h00;
    else       prev <= keycode;
  end

  assign press_valid = (keycode != 8'h00) && (keycode != prev);
  assign press_code  = press_valid ? keycode : 8'h00;

endmodule

// File: rtl/falling_block.sv
// rtl/falling_block.sv - grid-quantised falling game piece
// Purpose: spawns a piece, drops it one row every GRAV_PERIOD frames, moves it
// on A/D presses, soft-drops on S, and pulses landed when it locks.
// Configuration: define HARD_DROP_EN to enable the space-bar hard drop.
// Ports:
//   frame_clk  in   frame-rate clock
//   Reset      in   synchronous active-high reset
//   keycode    in   USB HID keycode (0 = none)
//   free_left/free_right/free_down  in  neighbouring cell empty
//   BlockX/BlockY  out  piece centre in pixels
//   BlockS     out  half-size in pixels
//   col/row    out  current cell
//   landed     out  one-frame pulse when the piece locks
module falling_block
  import falling_block_pkg::*;
#(
  parameter int COLS        = 10,
  parameter int ROWS        = 20,
  parameter int CELL        = 24,
  parameter int X_ORIGIN    = 200,
  parameter int Y_ORIGIN    = 0,
  parameter int GRAV_PERIOD = 30,
  parameter int SPAWN_COL   = 4
) (
  input  logic                     frame_clk,
  input  logic                     Reset,
  input  logic [7:0]               keycode,
  input  logic                     free_left,
  input  logic                     free_right,
  input  logic                     free_down,
  output logic [9:0]               BlockX,
  output logic [9:0]               BlockY,
  output logic [9:0]               BlockS,
  output logic [$clog2(COLS)-1:0]  col,
  output logic [$clog2(ROWS)-1:0]  row,
  output logic                     landed
);

  localparam int COL_W = $clog2(COLS);
  localparam int ROW_W = $clog2(ROWS);
  localparam int GC_W  = $clog2(GRAV_PERIOD);

  fb_state_t         state, state_n;
  logic [COL_W-1:0]  col_n;
  logic [ROW_W-1:0]  row_n;
  logic [GC_W-1:0]   gcnt, gcnt_n;

  logic [7:0] press_code;
  logic       press_valid;

  key_edge u_key_edge (
    .frame_clk   (frame_clk),
    .Reset       (Reset),
    .keycode     (keycode),
    .press_code  (press_code),
    .press_valid (press_valid)
  );

  logic can_down, is_a, is_d, is_s, step;
  assign can_down = (row != ROW_W'(ROWS - 1)) && free_down;
  assign is_a     = press_valid && (press_code == KEY_A);
  assign is_d     = press_valid && (press_code == KEY_D);
  assign is_s     = press_valid && (press_code == KEY_S);
`ifdef HARD_DROP_EN
  logic is_space;
  assign is_space = press_valid && (press_code == KEY_SPACE);
`endif

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state <= SPAWN;
      col   <= COL_W'(SPAWN_COL);
      row   <= '0;
      gcnt  <= '0;
    end else begin
      state <= state_n;
      col   <= col_n;
      row   <= row_n;
      gcnt  <= gcnt_n;
    end
  end

  always_comb begin
    state_n = state;
    col_n   = col;
    row_n   = row;
    gcnt_n  = gcnt;
    step    = 1'b0;
    case (state)
      SPAWN: begin
        col_n   = COL_W'(SPAWN_COL);
        row_n   = '0;
        gcnt_n  = '0;
        state_n = FALL;
      end
      FALL: begin
        if (is_a && col != '0 && free_left)
          col_n = col - COL_W'(1);
        else if (is_d && col != COL_W'(COLS - 1) && free_right)
          col_n = col + COL_W'(1);

        if (is_s) begin
          step   = 1'b1;
          gcnt_n = '0;
        end
`ifdef HARD_DROP_EN
        else if (is_space) begin
          gcnt_n = '0;
          if (can_down) begin
            row_n   = row + ROW_W'(1);
            state_n = DROP;
          end else begin
            state_n = LANDED;
          end
        end
`endif
        else if (gcnt == GC_W'(GRAV_PERIOD - 1)) begin
          // A horizontal press wins the frame; gravity waits one frame with gcnt held.
          if (!(is_a || is_d)) begin
            step   = 1'b1;
            gcnt_n = '0;
          end
        end else begin
          gcnt_n = gcnt + GC_W'(1);
        end

        if (step) begin
          if (can_down) row_n = row + ROW_W'(1);
          else          state_n = LANDED;
        end
      end
      LANDED: begin
        // Load the spawn position on the way out so SPAWN already shows it.
        col_n   = COL_W'(SPAWN_COL);
        row_n   = '0;
        gcnt_n  = '0;
        state_n = SPAWN;
      end
`ifdef HARD_DROP_EN
      DROP: begin
        if (can_down) row_n = row + ROW_W'(1);
        else          state_n = LANDED;
      end
`endif
      default: state_n = SPAWN;
    endcase
  end

  assign landed = (state == LANDED);
  assign BlockX = 10'(X_ORIGIN) + 10'(col) * 10'(CELL) + 10'(CELL / 2);
  assign BlockY = 10'(Y_ORIGIN) + 10'(row) * 10'(CELL) + 10'(CELL / 2);
  assign BlockS = 10'(CELL / 2);

endmodule

// File: tb/tb_falling_block.sv
// tb/tb_falling_block.sv - directed self-checking bench for falling_block
module tb_falling_block;

  logic       frame_clk = 1'b0;
  logic       Reset = 1'b1;
  logic [7:0] keycode = 8'h00;
  logic       free_left = 1'b1, free_right = 1'b1, free_down = 1'b1;
  logic [9:0] BlockX, BlockY, BlockS;
  logic [3:0] col;
  logic [4:0] row;
  logic       landed;

  int errors = 0;
  int checks = 0;

  falling_block dut (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .keycode   (keycode),
    .free_left (free_left),
    .free_right(free_right),
    .free_down (free_down),
    .BlockX    (BlockX),
    .BlockY    (BlockY),
    .BlockS    (BlockS),
    .col       (col),
    .row       (row),
    .landed    (landed)
  );

  always #5 frame_clk = ~frame_clk;

  task automatic tick(input int n);
    repeat (n) @(posedge frame_clk);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1; keycode = 8'h00;
    free_left = 1'b1; free_right = 1'b1; free_down = 1'b1;
    tick(1);
    Reset = 1'b0;
  endtask

  task automatic press(input logic [7:0] k);
    keycode = k; tick(1);
    keycode = 8'h00; tick(1);
  endtask

  task automatic test_reset();
    Reset = 1'b1; tick(2);
    checks++; if (col !== 4'd4) begin errors++; $display("FAIL reset_col got=%0d exp=4", col); end
    checks++; if (row !== 5'd0) begin errors++; $display("FAIL reset_row got=%0d exp=0", row); end
    checks++; if (BlockX !== 10'd308) begin errors++; $display("FAIL reset_x got=%0d exp=308", BlockX); end
    checks++; if (BlockY !== 10'd12) begin errors++; $display("FAIL reset_y got=%0d exp=12", BlockY); end
    checks++; if (BlockS !== 10'd12) begin errors++; $display("FAIL reset_s got=%0d exp=12", BlockS); end
    checks++; if (landed !== 1'b0) begin errors++; $display("FAIL reset_landed got=%0d exp=0", landed); end
  endtask

  task automatic test_gravity();
    do_reset();
    tick(30);
    checks++; if (row !== 5'd0) begin errors++; $display("FAIL grav_30 got=%0d exp=0", row); end
    tick(1);
    checks++; if (row !== 5'd1) begin errors++; $display("FAIL grav_31 got=%0d exp=1", row); end
    checks++; if (BlockY !== 10'd36) begin errors++; $display("FAIL grav_y got=%0d exp=36", BlockY); end
    tick(29);
    checks++; if (row !== 5'd1) begin errors++; $display("FAIL grav_60 got=%0d exp=1", row); end
    tick(1);
    checks++; if (row !== 5'd2) begin errors++; $display("FAIL grav_61 got=%0d exp=2", row); end
    checks++; if (BlockY !== 10'd60) begin errors++; $display("FAIL grav_y2 got=%0d exp=60", BlockY); end
  endtask

  task automatic test_move_left();
    do_reset();
    tick(1);
    keycode = 8'h04; tick(10);
    checks++; if (col !== 4'd3) begin errors++; $display("FAIL held_a got=%0d exp=3", col); end
    keycode = 8'h00; tick(1);
    for (int i = 0; i < 5; i++) press(8'h04);
    checks++; if (col !== 4'd0) begin errors++; $display("FAIL left_edge got=%0d exp=0", col); end
    checks++; if (BlockX !== 10'd212) begin errors++; $display("FAIL left_x got=%0d exp=212", BlockX); end
    checks++; if (row !== 5'd0) begin errors++; $display("FAIL left_row got=%0d exp=0", row); end
  endtask

  task automatic test_move_right();
    do_reset();
    tick(1);
    for (int i = 0; i < 7; i++) press(8'h07);
    checks++; if (col !== 4'd9) begin errors++; $display("FAIL right_edge got=%0d exp=9", col); end
    checks++; if (BlockX !== 10'd428) begin errors++; $display("FAIL right_x got=%0d exp=428", BlockX); end
    free_left = 1'b0;
    press(8'h04);
    checks++; if (col !== 4'd9) begin errors++; $display("FAIL blocked_left got=%0d exp=9", col); end
    free_left = 1'b1;
    press(8'h04);
    checks++; if (col !== 4'd8) begin errors++; $display("FAIL free_left got=%0d exp=8", col); end
  endtask

  task automatic test_landing();
    do_reset();
    tick(1);
    free_down = 1'b0;
    keycode = 8'h04; tick(1);
    keycode = 8'h00;
    tick(28);
    checks++; if (landed !== 1'b0) begin errors++; $display("FAIL land_early got=%0d exp=0", landed); end
    tick(1);
    checks++; if (landed !== 1'b1) begin errors++; $display("FAIL land_pulse got=%0d exp=1", landed); end
    checks++; if (col !== 4'd3) begin errors++; $display("FAIL land_col got=%0d exp=3", col); end
    tick(1);
    checks++; if (landed !== 1'b0) begin errors++; $display("FAIL land_once got=%0d exp=0", landed); end
    checks++; if (col !== 4'd4) begin errors++; $display("FAIL respawn_col got=%0d exp=4", col); end
    checks++; if (row !== 5'd0) begin errors++; $display("FAIL respawn_row got=%0d exp=0", row); end
  endtask

  task automatic test_key_on_gravity();
    do_reset();
    tick(30);
    keycode = 8'h04; tick(1);
    checks++; if (col !== 4'd3) begin errors++; $display("FAIL kg_col got=%0d exp=3", col); end
    checks++; if (row !== 5'd0) begin errors++; $display("FAIL kg_defer got=%0d exp=0", row); end
    keycode = 8'h00; tick(1);
    checks++; if (row !== 5'd1) begin errors++; $display("FAIL kg_step got=%0d exp=1", row); end
    tick(29);
    checks++; if (row !== 5'd1) begin errors++; $display("FAIL kg_hold got=%0d exp=1", row); end
    tick(1);
    checks++; if (row !== 5'd2) begin errors++; $display("FAIL kg_next got=%0d exp=2", row); end
  endtask

  task automatic test_soft_drop();
    do_reset();
    tick(5);
    press(8'h16);
    checks++; if (row !== 5'd1) begin errors++; $display("FAIL soft1 got=%0d exp=1", row); end
    keycode = 8'h16; tick(1);
    keycode = 8'h00;
    checks++; if (row !== 5'd2) begin errors++; $display("FAIL soft2 got=%0d exp=2", row); end
    tick(29);
    checks++; if (row !== 5'd2) begin errors++; $display("FAIL soft_gc got=%0d exp=2", row); end
    tick(1);
    checks++; if (row !== 5'd3) begin errors++; $display("FAIL soft_grav got=%0d exp=3", row); end
  endtask

  task automatic test_hard_drop();
    do_reset();
    tick(1);
    keycode = 8'h2C; tick(1);
    keycode = 8'h00;
`ifdef HARD_DROP_EN
    checks++; if (row !== 5'd1) begin errors++; $display("FAIL hd_first got=%0d exp=1", row); end
    tick(18);
    checks++; if (row !== 5'd19) begin errors++; $display("FAIL hd_bottom got=%0d exp=19", row); end
    checks++; if (landed !== 1'b0) begin errors++; $display("FAIL hd_early got=%0d exp=0", landed); end
    tick(1);
    checks++; if (landed !== 1'b1) begin errors++; $display("FAIL hd_landed got=%0d exp=1", landed); end
    tick(1);
    checks++; if (landed !== 1'b0) begin errors++; $display("FAIL hd_once got=%0d exp=0", landed); end
`else
    checks++; if (row !== 5'd0) begin errors++; $display("FAIL hd_ignored got=%0d exp=0", row); end
    tick(5);
    checks++; if (row !== 5'd0) begin errors++; $display("FAIL hd_still got=%0d exp=0", row); end
    checks++; if (landed !== 1'b0) begin errors++; $display("FAIL hd_nolanded got=%0d exp=0", landed); end
`endif
  endtask

  task automatic test_reset_mid();
    do_reset();
    tick(31);
    Reset = 1'b1; tick(1);
    checks++; if (row !== 5'd0) begin errors++; $display("FAIL rst_mid_row got=%0d exp=0", row); end
    do_reset();
    free_down = 1'b0;
    tick(31);
    checks++; if (landed !== 1'b1) begin errors++; $display("FAIL rst_pre_land got=%0d exp=1", landed); end
    Reset = 1'b1; tick(1);
    checks++; if (landed !== 1'b0) begin errors++; $display("FAIL rst_land got=%0d exp=0", landed); end
    Reset = 1'b0; tick(1);
    checks++; if (landed !== 1'b0) begin errors++; $display("FAIL rst_after got=%0d exp=0", landed); end
    checks++; if (col !== 4'd4) begin errors++; $display("FAIL rst_col got=%0d exp=4", col); end
  endtask

  initial begin
    test_reset();
    test_gravity();
    test_move_left();
    test_move_right();
    test_landing();
    test_key_on_gravity();
    test_soft_drop();
    test_hard_drop();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
